// File: rtl/student_coeff_pkg.sv
// Shared constants, state/error types and byte-merge helper for the coefficient memory.
package student_coeff_pkg;
    localparam int COEFF_W = 32;

    typedef enum logic {
        ST_IDLE,
        ST_RESP
    } fsm_state_e;

    typedef enum logic [2:0] {
        ERR_NONE,
        ERR_RANGE,
        ERR_ALIGN,
        ERR_SIZE,
        ERR_OPCODE,
        ERR_MASK
    } err_cause_e;

    function automatic logic [COEFF_W-1:0] merge_bytes(
        input logic [COEFF_W-1:0]   old_word,
        input logic [COEFF_W-1:0]   new_word,
        input logic [COEFF_W/8-1:0] mask
    );
        logic [COEFF_W-1:0] merged;
        merged = old_word;
        for (int b = 0; b < COEFF_W / 8; b++) begin
            if (mask[b]) begin
                merged[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return merged;
    endfunction
endpackage

// File: rtl/tlul_pkg.sv
// Minimal TL-UL channel types and opcodes shared by the mux and its device ports.
package tlul_pkg;
    localparam int TL_AW  = 32;
    localparam int TL_DW  = 32;
    localparam int TL_AIW = 8;
    localparam int TL_DIW = 1;
    localparam int TL_SZW = 2;
    localparam int TL_DBW = TL_DW / 8;

    localparam logic [2:0] PutFullData    = 3'h0;
    localparam logic [2:0] PutPartialData = 3'h1;
    localparam logic [2:0] Get            = 3'h4;

    localparam logic [2:0] AccessAck     = 3'h0;
    localparam logic [2:0] AccessAckData = 3'h1;

    typedef struct packed {
        logic              a_valid;
        logic [2:0]        a_opcode;
        logic [2:0]        a_param;
        logic [TL_SZW-1:0] a_size;
        logic [TL_AIW-1:0] a_source;
        logic [TL_AW-1:0]  a_address;
        logic [TL_DBW-1:0] a_mask;
        logic [TL_DW-1:0]  a_data;
        logic              d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic              d_valid;
        logic [2:0]        d_opcode;
        logic [2:0]        d_param;
        logic [TL_SZW-1:0] d_size;
        logic [TL_AIW-1:0] d_source;
        logic [TL_DIW-1:0] d_sink;
        logic [TL_DW-1:0]  d_data;
        logic              d_error;
        logic              a_ready;
    } tl_d2h_t;
endpackage

// File: rtl/student_tlul_req_check.sv
// Combinational A-channel legality check: flags illegal requests and extracts the word index.
module student_tlul_req_check
    import tlul_pkg::*;
    import student_coeff_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int OFFSET_W = 12,
    localparam int IDX_W   = $clog2(DEPTH)
) (
    input  logic [2:0]          opcode,
    input  logic [TL_SZW-1:0]   size,
    input  logic [TL_DBW-1:0]   mask,
    input  logic [OFFSET_W-1:0] offset,
    output logic                err,
    output logic [IDX_W-1:0]    index,
    output logic [2:0]          cause
);
    localparam int unsigned WINDOW_BYTES = DEPTH * 4;

    err_cause_e cause_e;

    // First failing rule wins so the debug cause is unambiguous.
    always_comb begin
        cause_e = ERR_NONE;
        if (32'(offset) >= WINDOW_BYTES) begin
            cause_e = ERR_RANGE;
        end else if (offset[1:0] != 2'b00) begin
            cause_e = ERR_ALIGN;
        end else if (size != 2'd2) begin
            cause_e = ERR_SIZE;
        end else if (opcode != Get && opcode != PutFullData && opcode != PutPartialData) begin
            cause_e = ERR_OPCODE;
        end else if (opcode == PutFullData && mask != 4'hF) begin
            cause_e = ERR_MASK;
        end
    end

    assign err   = (cause_e != ERR_NONE);
    assign index = offset[2 +: IDX_W];
    assign cause = cause_e;
endmodule

// File: rtl/student_tlul_coeff_mem.sv
// TL-UL coefficient memory with a registered datapath read port.
// Optional double buffering via STUDENT_COEFF_MEM_SHADOW_EN (bus->shadow, commit_i copies to active).
module student_tlul_coeff_mem
    import tlul_pkg::*;
    import student_coeff_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int OFFSET_W = 12,
    localparam int IDX_W   = $clog2(DEPTH)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  tl_h2d_t            tl_i,
    output tl_d2h_t            tl_o,
    input  logic [IDX_W-1:0]   coeff_addr_i,
    output logic [COEFF_W-1:0] coeff_o,
    input  logic               commit_i
);
    fsm_state_e          state;
    logic                d_valid_q;
    logic                d_error_q;
    logic [2:0]          d_opcode_q;
    logic [TL_SZW-1:0]   d_size_q;
    logic [TL_AIW-1:0]   d_source_q;
    logic [COEFF_W-1:0]  d_data_q;

    logic [COEFF_W-1:0]  bus_bank [DEPTH];

    logic                req_err;
    logic [IDX_W-1:0]    req_idx;
    logic [2:0]          req_cause;
    logic                accept;
    logic                is_get;
    logic                wr_en;
    logic [COEFF_W-1:0]  wr_word;
    logic                unused_sigs;

    student_tlul_req_check #(
        .DEPTH    (DEPTH),
        .OFFSET_W (OFFSET_W)
    ) u_req_check (
        .opcode (tl_i.a_opcode),
        .size   (tl_i.a_size),
        .mask   (tl_i.a_mask),
        .offset (tl_i.a_address[OFFSET_W-1:0]),
        .err    (req_err),
        .index  (req_idx),
        .cause  (req_cause)
    );

    assign accept  = tl_i.a_valid && (state == ST_IDLE);
    assign is_get  = (tl_i.a_opcode == Get);
    assign wr_en   = accept && !req_err && !is_get;
    assign wr_word = merge_bytes(bus_bank[req_idx], tl_i.a_data, tl_i.a_mask);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            d_valid_q  <= 1'b0;
            d_error_q  <= 1'b0;
            d_opcode_q <= '0;
            d_size_q   <= '0;
            d_source_q <= '0;
            d_data_q   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (tl_i.a_valid) begin
                        state      <= ST_RESP;
                        d_valid_q  <= 1'b1;
                        d_error_q  <= req_err;
                        d_opcode_q <= is_get ? AccessAckData : AccessAck;
                        d_size_q   <= tl_i.a_size;
                        d_source_q <= tl_i.a_source;
                        d_data_q   <= (is_get && !req_err) ? bus_bank[req_idx] : '0;
                    end
                end
                ST_RESP: begin
                    if (tl_i.d_ready) begin
                        state     <= ST_IDLE;
                        d_valid_q <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef STUDENT_COEFF_MEM_SHADOW_EN
    logic [COEFF_W-1:0] active_bank [DEPTH];

    // Commit copies the pre-edge shadow, so a write landing on the same edge stays shadow-only.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                bus_bank[i]    <= '0;
                active_bank[i] <= '0;
            end
        end else begin
            if (commit_i) begin
                for (int i = 0; i < DEPTH; i++) begin
                    active_bank[i] <= bus_bank[i];
                end
            end
            if (wr_en) begin
                bus_bank[req_idx] <= wr_word;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            coeff_o <= '0;
        end else begin
            coeff_o <= active_bank[coeff_addr_i];
        end
    end

    assign unused_sigs = ^{tl_i.a_param, tl_i.a_address[TL_AW-1:OFFSET_W], req_cause};
`else
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                bus_bank[i] <= '0;
            end
        end else if (wr_en) begin
            bus_bank[req_idx] <= wr_word;
        end
    end

    // Reads the pre-edge word, so a same-edge bus write shows up one cycle later.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            coeff_o <= '0;
        end else begin
            coeff_o <= bus_bank[coeff_addr_i];
        end
    end

    assign unused_sigs = ^{tl_i.a_param, tl_i.a_address[TL_AW-1:OFFSET_W], req_cause, commit_i};
`endif

    always_comb begin
        tl_o          = '0;
        tl_o.d_valid  = d_valid_q;
        tl_o.d_opcode = d_opcode_q;
        tl_o.d_param  = '0;
        tl_o.d_size   = d_size_q;
        tl_o.d_source = d_source_q;
        tl_o.d_sink   = '0;
        tl_o.d_data   = d_data_q;
        tl_o.d_error  = d_error_q;
        tl_o.a_ready  = (state == ST_IDLE);
    end
endmodule

// File: tb/tb_student_tlul_coeff_mem.sv
// Self-checking bench for student_tlul_coeff_mem: directed cases then randomized traffic vs an array model.
module tb_student_tlul_coeff_mem;
    import tlul_pkg::*;

    localparam int DEPTH = 16;
    localparam int IDX_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    tl_h2d_t          tl_h2d;
    tl_d2h_t          tl_d2h;
    logic [IDX_W-1:0] coeff_addr;
    logic [31:0]      coeff_o;
    logic             commit;

    logic [31:0] bus_model [DEPTH];
    logic [31:0] act_model [DEPTH];
    logic        pend_wr;
    logic [3:0]  pend_idx;
    logic [3:0]  pend_mask;
    logic [31:0] pend_data;
    logic [31:0] exp_coeff;
    logic        rand_commit;
    int          fixed_addr;
    int          n_vectors;
    int          n_miscompares;

    student_tlul_coeff_mem dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .tl_i         (tl_h2d),
        .tl_o         (tl_d2h),
        .coeff_addr_i (coeff_addr),
        .coeff_o      (coeff_o),
        .commit_i     (commit)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_vectors++;
        if (observed !== expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // One clock: check the datapath word read at the edge just passed, then fold that edge into the model.
    task automatic tick();
        @(negedge clk);
        checkOutput("coeff_o", coeff_o, rst ? 32'h0 : exp_coeff);
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                bus_model[i] = 32'h0;
                act_model[i] = 32'h0;
            end
        end else begin
`ifdef STUDENT_COEFF_MEM_SHADOW_EN
            if (commit) begin
                for (int i = 0; i < DEPTH; i++) act_model[i] = bus_model[i];
            end
`endif
            if (pend_wr) begin
                for (int b = 0; b < 4; b++) begin
                    if (pend_mask[b]) bus_model[pend_idx][8*b +: 8] = pend_data[8*b +: 8];
                end
`ifndef STUDENT_COEFF_MEM_SHADOW_EN
                act_model[pend_idx] = bus_model[pend_idx];
`endif
            end
        end
        pend_wr    = 1'b0;
        commit     = rand_commit ? ($urandom_range(0, 4) == 0) : 1'b0;
        coeff_addr = (fixed_addr >= 0) ? IDX_W'(fixed_addr) : IDX_W'($urandom);
        exp_coeff  = act_model[coeff_addr];
    endtask

    task automatic applyStimulus(
        input  logic [2:0]  op,
        input  logic [31:0] addr,
        input  logic [1:0]  size,
        input  logic [3:0]  mask,
        input  logic [31:0] data,
        input  int          hold,
        input  logic        accept_commit,
        output logic [31:0] rdata,
        output logic        rerr
    );
        logic [11:0] off;
        logic [3:0]  idx;
        logic        exp_err;
        logic [31:0] exp_data;
        logic [7:0]  src;
        off      = addr[11:0];
        idx      = addr[5:2];
        exp_err  = (off >= 12'd64) || (addr[1:0] != 2'b00) || (size != 2'd2) ||
                   !(op == Get || op == PutFullData || op == PutPartialData) ||
                   (op == PutFullData && mask != 4'hF);
        exp_data = (op == Get && !exp_err) ? bus_model[idx] : 32'h0;
        src      = 8'($urandom);

        checkOutput("a_ready_idle", 32'(tl_d2h.a_ready), 32'h1);
        tl_h2d.a_valid   = 1'b1;
        tl_h2d.a_opcode  = op;
        tl_h2d.a_param   = 3'($urandom);
        tl_h2d.a_size    = size;
        tl_h2d.a_source  = src;
        tl_h2d.a_address = addr;
        tl_h2d.a_mask    = mask;
        tl_h2d.a_data    = data;
        if (!exp_err && op != Get) begin
            pend_wr   = 1'b1;
            pend_idx  = idx;
            pend_mask = mask;
            pend_data = data;
        end
        if (accept_commit) commit = 1'b1;
        tick();

        // Scramble the A channel so the response must come from latched values.
        tl_h2d.a_valid   = 1'b0;
        tl_h2d.a_opcode  = 3'($urandom);
        tl_h2d.a_size    = 2'($urandom);
        tl_h2d.a_source  = 8'($urandom);
        tl_h2d.a_address = $urandom;
        tl_h2d.a_data    = $urandom;
        rdata = tl_d2h.d_data;
        rerr  = tl_d2h.d_error;
        for (int c = 0; c <= hold; c++) begin
            if (c > 0) tick();
            checkOutput("d_valid", 32'(tl_d2h.d_valid), 32'h1);
            checkOutput("a_ready_busy", 32'(tl_d2h.a_ready), 32'h0);
            checkOutput("d_opcode", 32'(tl_d2h.d_opcode), (op == Get) ? 32'(AccessAckData) : 32'(AccessAck));
            checkOutput("d_error", 32'(tl_d2h.d_error), 32'(exp_err));
            checkOutput("d_data", tl_d2h.d_data, exp_data);
            checkOutput("d_source", 32'(tl_d2h.d_source), 32'(src));
            checkOutput("d_size", 32'(tl_d2h.d_size), 32'(size));
            checkOutput("d_param_sink", 32'({tl_d2h.d_param, tl_d2h.d_sink}), 32'h0);
        end
        tl_h2d.d_ready = 1'b1;
        tick();
        tl_h2d.d_ready = 1'b0;
        checkOutput("d_valid_done", 32'(tl_d2h.d_valid), 32'h0);
        checkOutput("a_ready_done", 32'(tl_d2h.a_ready), 32'h1);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [3:0]  mask;
        int          sel;

        n_vectors     = 0;
        n_miscompares = 0;
        rst           = 1'b1;
        tl_h2d        = '0;
        commit        = 1'b0;
        coeff_addr    = '0;
        pend_wr       = 1'b0;
        pend_idx      = '0;
        pend_mask     = '0;
        pend_data     = '0;
        exp_coeff     = 32'h0;
        rand_commit   = 1'b0;
        fixed_addr    = -1;
        for (int i = 0; i < DEPTH; i++) begin
            bus_model[i] = 32'h0;
            act_model[i] = 32'h0;
        end

        repeat (3) tick();
        checkOutput("rst_d_valid", 32'(tl_d2h.d_valid), 32'h0);
        checkOutput("rst_a_ready", 32'(tl_d2h.a_ready), 32'h1);
        checkOutput("rst_d_fields", 32'({tl_d2h.d_opcode, tl_d2h.d_size, tl_d2h.d_source, tl_d2h.d_error}), 32'h0);
        checkOutput("rst_d_data", tl_d2h.d_data, 32'h0);
        rst = 1'b0;
        tick();

        fixed_addr = 3;
        applyStimulus(PutFullData, 32'h0000_000C, 2'd2, 4'hF, 32'hDEAD_BEEF, 0, 1'b0, rd, er);
        checkOutput("t1_put_err", 32'(er), 32'h0);
        applyStimulus(Get, 32'h0000_000C, 2'd2, 4'hF, 32'h0, 0, 1'b0, rd, er);
        checkOutput("t1_get_data", rd, 32'hDEAD_BEEF);

        applyStimulus(PutPartialData, 32'h0000_000C, 2'd2, 4'b0101, 32'h1122_3344, 0, 1'b0, rd, er);
`ifndef STUDENT_COEFF_MEM_SHADOW_EN
        checkOutput("t2_coeff", coeff_o, 32'hDE22_BE44);
`endif
        applyStimulus(Get, 32'h0000_000C, 2'd2, 4'hF, 32'h0, 0, 1'b0, rd, er);
        checkOutput("t2_get_data", rd, 32'hDE22_BE44);

        applyStimulus(Get, 32'h0000_0040, 2'd2, 4'hF, 32'h0, 0, 1'b0, rd, er);
        checkOutput("t3_range_err", 32'(er), 32'h1);
        applyStimulus(Get, 32'h0000_0002, 2'd2, 4'hF, 32'h0, 0, 1'b0, rd, er);
        checkOutput("t3_align_err", 32'(er), 32'h1);
        applyStimulus(PutFullData, 32'h0000_000C, 2'd2, 4'h3, 32'h5555_5555, 0, 1'b0, rd, er);
        checkOutput("t3_mask_err", 32'(er), 32'h1);
        applyStimulus(PutFullData, 32'h0000_000C, 2'd1, 4'hF, 32'h6666_6666, 0, 1'b0, rd, er);
        checkOutput("t3_size_err", 32'(er), 32'h1);
        applyStimulus(Get, 32'h0000_000C, 2'd2, 4'hF, 32'h0, 5, 1'b0, rd, er);
        checkOutput("t3_unchanged", rd, 32'hDE22_BE44);

        // Response dropped by a reset while it is still pending.
        tl_h2d.a_valid   = 1'b1;
        tl_h2d.a_opcode  = Get;
        tl_h2d.a_size    = 2'd2;
        tl_h2d.a_address = 32'h0000_000C;
        tl_h2d.a_mask    = 4'hF;
        tick();
        tl_h2d.a_valid = 1'b0;
        checkOutput("t5_in_resp", 32'(tl_d2h.d_valid), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("t5_d_valid", 32'(tl_d2h.d_valid), 32'h0);
        checkOutput("t5_a_ready", 32'(tl_d2h.a_ready), 32'h1);
        tick();
        applyStimulus(Get, 32'h0000_0000, 2'd2, 4'hF, 32'h0, 1, 1'b0, rd, er);
        checkOutput("t5_get0", rd, 32'h0);
        applyStimulus(Get, 32'h0000_000C, 2'd2, 4'hF, 32'h0, 0, 1'b0, rd, er);
        checkOutput("t5_get3", rd, 32'h0);

`ifdef STUDENT_COEFF_MEM_SHADOW_EN
        fixed_addr = 1;
        applyStimulus(PutFullData, 32'h0000_0004, 2'd2, 4'hF, 32'h5, 0, 1'b0, rd, er);
        tick();
        checkOutput("t6_pre_commit", coeff_o, 32'h0);
        commit = 1'b1;
        tick();
        tick();
        checkOutput("t6_post_commit", coeff_o, 32'h5);
        applyStimulus(PutFullData, 32'h0000_0004, 2'd2, 4'hF, 32'h9, 0, 1'b1, rd, er);
        tick();
        checkOutput("t6_same_edge", coeff_o, 32'h5);
        commit = 1'b1;
        tick();
        tick();
        checkOutput("t6_second_commit", coeff_o, 32'h9);
`endif

        fixed_addr  = -1;
        rand_commit = 1'b1;
        for (int n = 0; n < 300; n++) begin
            sel = $urandom_range(0, 9);
            if (sel < 3)      op = Get;
            else if (sel < 6) op = PutFullData;
            else if (sel < 8) op = PutPartialData;
            else              op = 3'($urandom);
            if ($urandom_range(0, 7) == 0) addr = $urandom;
            else addr = {20'($urandom), 6'h0, 4'($urandom), 2'b00};
            size = ($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'd2;
            if (op == PutFullData && $urandom_range(0, 4) != 0) mask = 4'hF;
            else mask = 4'($urandom);
            applyStimulus(op, addr, size, mask, $urandom, $urandom_range(0, 3), 1'b0, rd, er);
        end
        rand_commit = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end
endmodule
